// File: rtl/uart_bus_master_if.sv
// Word bus shared with the CPU: valid/ready handshake, address, data and strobes.
interface uart_bus_master_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  logic              mem_valid;
  logic              mem_instr;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART command decoder that issues single-word reads/writes on the CPU bus
// and answers with an ACK, NAK or the four read-data bytes.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       received,
  input  logic [7:0] rx_byte,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting,
  output logic       busy,
  uart_bus_master_if.master bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TMO_W  = 32;
  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               is_write_q, is_write_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WORD_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  resp_q, resp_d;
  logic [1:0]         resp_idx_q, resp_idx_d;
  logic [1:0]         resp_last_q, resp_last_d;
  logic               resp_done_q, resp_done_d;
  logic               guard_q, guard_d;
  logic               transmit_q, transmit_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               mem_valid_q, mem_valid_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic               busy_q, busy_d;
  logic               tmo_hit_c;

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 32'd1));

  // State register; reset abandons any in-flight bus cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: byte-driven collection, bus handshake, response drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (received) begin
          if (rx_byte == OP_WRITE || rx_byte == OP_READ) state_d = S_ADDR;
          else                                           state_d = S_RESP;
        end
      end
      S_ADDR: begin
        if (received) begin
          if (cnt_q == 2'd3) state_d = is_write_q ? S_DATA : S_BUS;
        end else if (tmo_hit_c) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (received) begin
          if (cnt_q == 2'd3) state_d = S_BUS;
        end else if (tmo_hit_c) begin
          state_d = S_IDLE;
        end
      end
      S_BUS:  if (bus.mem_ready) state_d = S_RESP;
      S_RESP: if (resp_done_q)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, derived from the current and next state.
  always_comb begin
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    resp_idx_d  = resp_idx_q;
    resp_last_d = resp_last_q;
    resp_done_d = resp_done_q;
    guard_d     = 1'b0;
    transmit_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    unique case (state_q)
      S_IDLE: begin
        if (received) begin
          is_write_d  = (rx_byte == OP_WRITE);
          cnt_d       = 2'd0;
          resp_d      = WORD_W'(RSP_NAK);
          resp_idx_d  = 2'd0;
          resp_last_d = 2'd0;
          resp_done_d = 1'b0;
        end
      end
      S_ADDR: begin
        if (received) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          addr_d[1:0] = 2'b00;
          cnt_d = cnt_q + 2'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DATA: begin
        if (received) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d = cnt_q + 2'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_BUS: begin
        if (bus.mem_ready) begin
          resp_d      = is_write_q ? WORD_W'(RSP_ACK) : bus.mem_rdata;
          resp_idx_d  = 2'd0;
          resp_last_d = is_write_q ? 2'd0 : 2'd3;
          resp_done_d = 1'b0;
        end
      end
      S_RESP: begin
        // Guard masks is_transmitting in the pulse cycle, before the UART reacts.
        if (!resp_done_q && !guard_q && !is_transmitting) begin
          transmit_d = 1'b1;
          guard_d    = 1'b1;
          tx_byte_d  = resp_q[{resp_idx_q, 3'b000} +: 8];
          resp_idx_d = resp_idx_q + 2'd1;
          if (resp_idx_q == resp_last_q) resp_done_d = 1'b1;
        end
      end
      default: ;
    endcase
    mem_valid_d = (state_d == S_BUS);
    mem_wstrb_d = (state_d == S_BUS && is_write_q) ? 4'b1111 : 4'b0000;
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      resp_idx_q  <= '0;
      resp_last_q <= '0;
      resp_done_q <= 1'b0;
      guard_q     <= 1'b0;
      transmit_q  <= 1'b0;
      tx_byte_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_wstrb_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      resp_idx_q  <= resp_idx_d;
      resp_last_q <= resp_last_d;
      resp_done_q <= resp_done_d;
      guard_q     <= guard_d;
      transmit_q  <= transmit_d;
      tx_byte_q   <= tx_byte_d;
      mem_valid_q <= mem_valid_d;
      mem_wstrb_q <= mem_wstrb_d;
      busy_q      <= busy_d;
    end
  end

  assign transmit      = transmit_q;
  assign tx_byte       = tx_byte_q;
  assign busy          = busy_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench: command vectors with hand-computed bus/UART expectations,
// plus timeout and mid-operation reset sequences.
module tb_uart_bus_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting = 1'b0;
  logic       busy;

  uart_bus_master_if bus ();

  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .received        (received),
    .rx_byte         (rx_byte),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .busy            (busy),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Bus responder / monitor state
  int          ready_wait = 0;
  logic [31:0] rdata_val = '0;
  int          vcnt = 0;
  int          ntrans = 0;
  int          vcyc = 0;
  int          unstable = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  // UART transmitter model state
  int         tcnt = 0;
  int         overlap = 0;
  logic [7:0] tx_q[$];

  typedef struct {
    logic [71:0] cmd;        // bytes in send order, first byte in [71:64]
    int          n;
    int          wait_c;
    logic [31:0] rdata;
    int          exp_trans;
    int          exp_vcyc;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          chk_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_ntx;
    logic [31:0] exp_tx;     // first transmitted byte in [7:0]
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial bus.mem_ready = 1'b0;
  initial bus.mem_rdata = '0;

  // Responder: ready after ready_wait valid cycles; monitor stability of request.
  always @(negedge clk) begin
    if (bus.mem_valid) begin
      if (!prev_valid) begin
        ntrans++;
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_wstrb = bus.mem_wstrb;
      end else if (bus.mem_addr !== cap_addr || bus.mem_wdata !== cap_wdata ||
                   bus.mem_wstrb !== cap_wstrb) begin
        unstable++;
      end
      vcyc++;
      if (vcnt == ready_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata_val;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0BAD0;
      end
      vcnt++;
    end else begin
      bus.mem_ready = 1'b0;
      vcnt = 0;
    end
    prev_valid = bus.mem_valid;
  end

  // UART transmitter: busy for ~10 cycles after each pulse.
  always @(negedge clk) begin
    if (transmit) begin
      if (is_transmitting) overlap++;
      tx_q.push_back(tx_byte);
      tcnt = 10;
    end else if (tcnt > 0) begin
      tcnt--;
    end
    is_transmitting = (tcnt > 0);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic clear_mon();
    ntrans   = 0;
    vcyc     = 0;
    unstable = 0;
    overlap  = 0;
    tx_q.delete();
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [71:0] c;
    int k;
    c = v.cmd;
    ready_wait = v.wait_c;
    rdata_val  = v.rdata;
    clear_mon();
    for (int i = 0; i < v.n; i++) begin
      send_byte(c[71-8*i -: 8]);
      if (i == 0) chk({name, "_busy_rise"}, 32'(busy), 32'd1);
    end
    // one cycle after the last byte
    chk({name, "_valid_t1"}, 32'(bus.mem_valid), (v.exp_trans > 0) ? 32'd1 : 32'd0);
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, 32'(busy), 32'd0);
    repeat (14) @(negedge clk);
    chk({name, "_ntrans"}, 32'(ntrans), 32'(v.exp_trans));
    if (v.exp_trans > 0) begin
      chk({name, "_vcyc"}, 32'(vcyc), 32'(v.exp_vcyc));
      chk({name, "_addr"}, cap_addr, v.exp_addr);
      chk({name, "_wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
      chk({name, "_stable"}, 32'(unstable), 32'd0);
      if (v.chk_wdata) chk({name, "_wdata"}, cap_wdata, v.exp_wdata);
    end
    chk({name, "_ntx"}, 32'(tx_q.size()), 32'(v.exp_ntx));
    for (int i = 0; i < v.exp_ntx; i++) begin
      if (i < tx_q.size()) chk({name, "_txbyte"}, 32'(tx_q[i]), 32'(v.exp_tx[8*i +: 8]));
    end
    chk({name, "_overlap"}, 32'(overlap), 32'd0);
    chk({name, "_valid_idle"}, 32'(bus.mem_valid), 32'd0);
  endtask

  initial begin
    int k;
    vecs[0] = '{cmd: 72'h57_00100000_EFBEADDE, n: 9, wait_c: 3, rdata: 32'h0,
                exp_trans: 1, exp_vcyc: 4, exp_addr: 32'h00001000, exp_wdata: 32'hDEADBEEF,
                chk_wdata: 1'b1, exp_wstrb: 4'b1111, exp_ntx: 1, exp_tx: 32'h06};
    vecs[1] = '{cmd: 72'h52_040000F0_00000000, n: 5, wait_c: 1, rdata: 32'h12345678,
                exp_trans: 1, exp_vcyc: 2, exp_addr: 32'hF0000004, exp_wdata: 32'h0,
                chk_wdata: 1'b0, exp_wstrb: 4'b0000, exp_ntx: 4, exp_tx: 32'h12345678};
    vecs[2] = '{cmd: 72'h41_00000000_00000000, n: 1, wait_c: 0, rdata: 32'h0,
                exp_trans: 0, exp_vcyc: 0, exp_addr: 32'h0, exp_wdata: 32'h0,
                chk_wdata: 1'b0, exp_wstrb: 4'b0000, exp_ntx: 1, exp_tx: 32'h15};
    vecs[3] = '{cmd: 72'h52_03200000_00000000, n: 5, wait_c: 0, rdata: 32'hA5A50001,
                exp_trans: 1, exp_vcyc: 1, exp_addr: 32'h00002000, exp_wdata: 32'h0,
                chk_wdata: 1'b0, exp_wstrb: 4'b0000, exp_ntx: 4, exp_tx: 32'hA5A50001};
    vecs[4] = '{cmd: 72'h57_FCFFFFFF_01020304, n: 9, wait_c: 0, rdata: 32'h0,
                exp_trans: 1, exp_vcyc: 1, exp_addr: 32'hFFFFFFFC, exp_wdata: 32'h04030201,
                chk_wdata: 1'b1, exp_wstrb: 4'b1111, exp_ntx: 1, exp_tx: 32'h06};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_instr", 32'(bus.mem_instr), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Timeout: opcode plus one address byte, then silence.
    clear_mon();
    send_byte(8'h57);
    send_byte(8'h00);          // now at the cycle after this byte
    repeat (94) @(negedge clk);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_ntrans", 32'(ntrans), 32'd0);
    chk("tmo_ntx", 32'(tx_q.size()), 32'd0);
    run_vec("tmo_read", vecs[1]);

    // Reset while a bus cycle is outstanding.
    clear_mon();
    ready_wait = 100000;
    send_byte(8'h52);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("mid_valid_pre", 32'(bus.mem_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_valid_rst", 32'(bus.mem_valid), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_transmit_rst", 32'(transmit), 32'd0);
    chk("mid_addr_rst", bus.mem_addr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    k = 0;
    chk("mid_busy_rel", 32'(busy), 32'd0);
    run_vec("mid_read", vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
